mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester, round-robin arbiter sharing the single data port (rw/ain/din/dout) of the 1024×32 synchronous memory. Requester 0 is the CPU load/store stage, requester 1 is the loader/debug DMA. Pipelined: one access issued per cycle, each response returned exactly two cycles after acceptance. The instruction port of the memory is untouched.

## Interface
- MEM_WORDS, 1024, number of 32-bit words; legal word addresses are 0..MEM_WORDS-1
- DATA_W, 32, data width
- clock  in  1  rising-edge clock shared with memory
- reset  in  1  synchronous, active-high
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (transfer = valid && ready at rising edge)
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  32  word address
- req0_wdata / req1_wdata  in  DATA_W  write data
- rsp0_valid / rsp1_valid  out  1  one-cycle response pulse
- rsp0_rdata / rsp1_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp0_err / rsp1_err  out  1  address ≥ MEM_WORDS
- mem_rw  out  1  to memory rw
- mem_ain  out  32  to memory ain
- mem_din  out  DATA_W  to memory din
- mem_dout  in  DATA_W  from memory dout (valid the cycle after issue)

## Operation
- Arbitration: combinational grant among valid requesters; tie broken by round-robin pointer `last` (port granted most recently loses the tie). Single requester always granted immediately.
- reqK_ready = grantK; ready may depend on own valid; requesters must not gate valid on ready. Only one ready high per cycle.
- On transfer, `last` ← granted port. No transfer → `last` unchanged.
- Issue (same cycle as transfer): mem_ain = addr, mem_din = wdata, mem_rw = we && in_range. Idle or out-of-range: mem_rw = 0 (no stray or wrapped writes); mem_ain/mem_din hold granted values or 0 when idle.
- in_range = addr < MEM_WORDS, full 32-bit compare (no truncation/wrap).
- Pipeline stage 1 (registered at issue edge): valid, port id, we, err.
- Stage 2 (registered at next edge): rspK_valid for the recorded port, rdata = mem_dout if read && !err else 0, err copied.
- Responses have no backpressure; requesters must sink every pulse.
- Back-to-back accepts allowed; responses return in issue order, one per cycle max.

## Timing
- Transfer in cycle N → memory samples at end of N → mem_dout valid in N+1 → rspK_valid high in N+2 only.
- Throughput: 1 access/cycle. Both requesters continuously valid → grants alternate 0,1,0,1; worst-case wait 1 cycle.
- Reset (sampled at edge): all stage registers cleared, rsp*_valid = 0, rsp*_rdata = 0, rsp*_err = 0 from the next cycle; `last` = 1 so port 0 wins first tie. During reset high: req*_ready = 0, mem_rw = 0.
- Reset mid-flight: in-flight responses discarded (never delivered); a write issued in the same cycle reset is high is not performed.
- Read and write to same address in consecutive cycles: memory ordering governs; write issued in N is visible to a read issued in N+1.

## Structure
- Package mem_arb_pkg: MEM_WORDS, DATA_W defaults, PORT_CPU = 0, PORT_DMA = 1 constants, pipeline-stage record typedef (valid, port, we, err).
- Sub-module mem_arb_rr: 2-way round-robin grant + `last` pointer register (clock, reset, valid[1:0], accept → grant[1:0]).
- Top holds issue muxing, range check and two pipeline stages; 150–250 RTL lines total.

## Test plan
- Port 0 write addr 5 data 0xDEADBEEF (N), port 0 read addr 5 (N+1) → rsp0_valid at N+2 (err 0, rdata 0), rsp0_valid at N+3 with rdata 0xDEADBEEF.
- Both valid continuously from reset with reads at 1 and 2 → grants 0,1,0,1…; rsp pulses alternate ports every cycle, each exactly 2 cycles after its accept.
- Port 1 write addr 1024 data 0x1 → mem_rw stays 0, rsp1_err = 1 at N+2; subsequent read addr 0 returns preloaded value unchanged.
- Only port 1 valid for 4 cycles then port 0 joins while port 1 stays valid → port 0 granted the first joint cycle (last = 1).
- Reset asserted the cycle after a read accept → no rsp*_valid ever emitted for it; outputs zero; first post-reset tie goes to port 0.
- Idle (no valid) for 10 cycles → mem_rw = 0 throughout, no rsp pulses, memory contents unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants and pipeline record for the two-port memory data-port arbiter.
package mem_arb_pkg;

  localparam int unsigned DEFAULT_MEM_WORDS = 1024;
  localparam int unsigned DEFAULT_DATA_W    = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
    logic we;
    logic err;
  } stage_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant; the most recently granted port loses a tie.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_q, last_d;

  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (last_q == PORT_CPU) ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign last_d = accept ? grant[1] : last_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= PORT_DMA;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of the memory data port between CPU and DMA; responses two cycles after accept.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_WORDS = DEFAULT_MEM_WORDS,
  parameter int unsigned DATA_W    = DEFAULT_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [31:0]       req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [31:0]       req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic              mem_rw,
  output logic [31:0]       mem_ain,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  logic [1:0]        valid, grant;
  logic              accept, sel_we, in_range;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  stage_t            s1_d, s1_q;
  logic [1:0]        rsp_valid_d, rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_d, rsp_rdata_q;
  logic              rsp_err_d, rsp_err_q;

  assign valid  = {req1_valid, req0_valid};
  assign accept = |(valid & grant);

  mem_arb_rr u_rr (
    .clock  (clock),
    .reset  (reset),
    .valid  (valid),
    .accept (accept),
    .grant  (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (grant[0]) begin
      sel_we    = req0_we;
      sel_addr  = req0_addr;
      sel_wdata = req0_wdata;
    end else if (grant[1]) begin
      sel_we    = req1_we;
      sel_addr  = req1_addr;
      sel_wdata = req1_wdata;
    end
  end

  // Full-width compare so addresses above the array never alias onto it.
  assign in_range = (sel_addr < MEM_WORDS);

  assign mem_ain = sel_addr;
  assign mem_din = sel_wdata;
  assign mem_rw  = accept && sel_we && in_range;

  always_comb begin
    s1_d = '0;
    if (accept) begin
      s1_d.valid = 1'b1;
      s1_d.port  = grant[1];
      s1_d.we    = sel_we;
      s1_d.err   = !in_range;
    end
  end

  always_comb begin
    rsp_valid_d = 2'b00;
    if (s1_q.valid) begin
      rsp_valid_d[s1_q.port] = 1'b1;
    end
    rsp_rdata_d = (s1_q.valid && !s1_q.we && !s1_q.err) ? mem_dout : '0;
    rsp_err_d   = s1_q.valid && s1_q.err;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q        <= '0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_rdata = rsp_valid_q[0] ? rsp_rdata_q : '0;
  assign rsp1_rdata = rsp_valid_q[1] ? rsp_rdata_q : '0;
  assign rsp0_err   = rsp_valid_q[0] && rsp_err_q;
  assign rsp1_err   = rsp_valid_q[1] && rsp_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a behavioural 1024x32 synchronous memory.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
  logic [31:0] req0_addr = '0, req0_wdata = '0, req1_addr = '0, req1_wdata = '0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        mem_rw;
  logic [31:0] mem_ain, mem_din;
  logic [31:0] mem_dout = '0;

  always #5 clock = ~clock;

  mem_port_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp0_err   (rsp0_err),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .rsp1_err   (rsp1_err),
    .mem_rw     (mem_rw),
    .mem_ain    (mem_ain),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  // Memory model: read-before-write, so a write in N is seen by a read issued in N+1.
  logic [31:0] mem [0:1023];
  logic        preload = 1'b1;

  always @(posedge clock) begin
    if (preload) begin
      mem[0] <= 32'hA0A0_0000;
      mem[1] <= 32'h1111_1111;
      mem[2] <= 32'h2222_2222;
      mem[5] <= 32'h5555_5555;
      mem[6] <= 32'h6666_6666;
    end else if (mem_rw) begin
      mem[mem_ain[9:0]] <= mem_din;
    end
    mem_dout <= mem[mem_ain[9:0]];
  end

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse is matched against the head of the scoreboard.
  exp_t e;
  always @(negedge clock) begin
    if (rsp0_valid && rsp1_valid) begin
      checks++;
      errors++;
      $display("FAIL rsp_both: both response pulses high at cycle %0d", cyc);
    end else if (rsp0_valid || rsp1_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: port %0d pulse with none expected at cycle %0d",
                 rsp1_valid, cyc);
      end else begin
        e = q.pop_front();
        check("rsp_port", {31'b0, rsp1_valid}, {31'b0, e.port});
        check("rsp_rdata", rsp1_valid ? rsp1_rdata : rsp0_rdata, e.rdata);
        check("rsp_err", {31'b0, rsp1_valid ? rsp1_err : rsp0_err}, {31'b0, e.err});
        check("rsp_cycle", cyc, e.due);
      end
    end else if (q.size() != 0 && q[0].due < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL rsp_missing: port %0d response due cycle %0d not seen by %0d",
               e.port, e.due, cyc);
    end
  end

  // One cycle of stimulus; checks grant and mem_rw, and optionally queues the expected response.
  task automatic step(input logic v0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic v1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                      input logic [1:0] eg, input logic ewr, input logic push,
                      input logic [31:0] erd, input logic eerr);
    exp_t x;
    req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
    @(negedge clock);
    check("ready", {30'b0, req1_ready, req0_ready}, {30'b0, eg});
    check("mem_rw", {31'b0, mem_rw}, {31'b0, ewr});
    if (push) begin
      x.port  = eg[1];
      x.rdata = erd;
      x.err   = eerr;
      x.due   = cyc + 2;
      q.push_back(x);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_valid"}, {30'b0, rsp1_valid, rsp0_valid}, 32'h0);
    check({name, "_rdata0"}, rsp0_rdata, 32'h0);
    check({name, "_rdata1"}, rsp1_rdata, 32'h0);
    check({name, "_err"}, {30'b0, rsp1_err, rsp0_err}, 32'h0);
  endtask

  initial begin
    @(posedge clock);
    #1;
    preload = 1'b0;
    // Requests during reset: no ready, no write (addr 6 write must not land).
    step(1, 1, 32'd5, 32'h1234, 1, 1, 32'd6, 32'h5678, 2'b00, 0, 0, 0, 0);
    reset = 1'b0;
    check_quiet("reset_out");

    // Write then read-back on port 0.
    step(1, 1, 32'd5, 32'hDEADBEEF, 0, 0, 0, 0, 2'b01, 1, 1, 32'h0, 0);
    step(1, 0, 32'd5, 32'h0, 0, 0, 0, 0, 2'b01, 0, 1, 32'hDEADBEEF, 0);
    idle(3);

    // Both continuously valid from reset: strict alternation starting at port 0.
    reset = 1'b1;
    step(1, 0, 32'd1, 0, 1, 0, 32'd2, 0, 2'b00, 0, 0, 0, 0);
    reset = 1'b0;
    step(1, 0, 32'd1, 0, 1, 0, 32'd2, 0, 2'b01, 0, 1, 32'h1111_1111, 0);
    step(1, 0, 32'd1, 0, 1, 0, 32'd2, 0, 2'b10, 0, 1, 32'h2222_2222, 0);
    step(1, 0, 32'd1, 0, 1, 0, 32'd2, 0, 2'b01, 0, 1, 32'h1111_1111, 0);
    step(1, 0, 32'd1, 0, 1, 0, 32'd2, 0, 2'b10, 0, 1, 32'h2222_2222, 0);
    idle(3);

    // Out-of-range write: no memory write, error response, addr 0 and addr 6 untouched.
    step(0, 0, 0, 0, 1, 1, 32'd1024, 32'h1, 2'b10, 0, 1, 32'h0, 1);
    step(0, 0, 0, 0, 1, 0, 32'd0, 0, 2'b10, 0, 1, 32'hA0A0_0000, 0);
    step(0, 0, 0, 0, 1, 0, 32'd6, 0, 2'b10, 0, 1, 32'h6666_6666, 0);
    step(0, 0, 0, 0, 1, 1, 32'h8000_0005, 32'h7, 2'b10, 0, 1, 32'h0, 1);
    idle(3);

    // Port 1 alone for 4 cycles, then port 0 joins and wins the first joint cycle.
    repeat (4) step(0, 0, 0, 0, 1, 0, 32'd2, 0, 2'b10, 0, 1, 32'h2222_2222, 0);
    step(1, 0, 32'd1, 0, 1, 0, 32'd2, 0, 2'b01, 0, 1, 32'h1111_1111, 0);
    step(1, 0, 32'd1, 0, 1, 0, 32'd2, 0, 2'b10, 0, 1, 32'h2222_2222, 0);
    idle(3);

    // Reset the cycle after a read accept: that response must never appear.
    step(1, 0, 32'd5, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    reset = 1'b1;
    step(1, 0, 32'd1, 0, 1, 0, 32'd2, 0, 2'b00, 0, 0, 0, 0);
    reset = 1'b0;
    check_quiet("flush_out");
    step(1, 0, 32'd1, 0, 1, 0, 32'd2, 0, 2'b01, 0, 1, 32'h1111_1111, 0);
    idle(3);

    // Long idle: no writes, no pulses, contents unchanged.
    idle(10);
    step(1, 0, 32'd5, 0, 0, 0, 0, 0, 2'b01, 0, 1, 32'hDEADBEEF, 0);
    idle(4);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses never arrived, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
